// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipeline through hold_flag_o until the result pulses out.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic [4:0]      reg_waddr_o,
  output logic            hold_flag_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic HoldEnable  = 1'b1;
  localparam logic HoldDisable = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            isrem_q, isrem_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;

  logic            go;
  logic            sgn_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, ovf;
  logic [XLEN:0]   rem_sh, diff;
  logic            sub_ok;
  logic [XLEN-1:0] rem_nx, quot_nx;
  logic [XLEN-1:0] q_fin, r_fin;

  // op_i[2] marks the divide group of funct3
  assign go     = start_i & op_i[2];
  assign sgn_op = ~op_i[0];
  assign a_neg  = sgn_op & dividend_i[XLEN-1];
  assign b_neg  = sgn_op & divisor_i[XLEN-1];
  assign a_mag  = a_neg ? -dividend_i : dividend_i;
  assign b_mag  = b_neg ? -divisor_i : divisor_i;

  assign div_zero = (divisor_i == '0);
  assign ovf = sgn_op
             & (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
             & (divisor_i == '1);

  assign rem_sh  = {rem_q, quot_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvsr_q};
  assign sub_ok  = ~diff[XLEN];
  assign rem_nx  = sub_ok ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quot_nx = {quot_q[XLEN-2:0], sub_ok};

  assign q_fin = negq_q ? -quot_nx : quot_nx;
  assign r_fin = negr_q ? -rem_nx : rem_nx;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    dvsr_d      = dvsr_q;
    result_d    = result_q;
    waddr_d     = waddr_q;
    cnt_d       = cnt_q;
    isrem_d     = isrem_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    hold_flag_o = HoldDisable;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          hold_flag_o = HoldEnable;
          isrem_d     = op_i[1];
          waddr_d     = reg_waddr_i;
          rem_d       = '0;
          quot_d      = a_mag;
          dvsr_d      = b_mag;
          negq_d      = a_neg ^ b_neg;
          negr_d      = a_neg;
          cnt_d       = '0;
          if (div_zero) begin
            result_d = op_i[1] ? dividend_i : '1;
            state_d  = DONE;
          end else if (ovf) begin
            result_d = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hold_flag_o = HoldEnable;
        rem_d       = rem_nx;
        quot_d      = quot_nx;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          result_d = isrem_q ? r_fin : q_fin;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      waddr_q  <= '0;
      cnt_q    <= '0;
      isrem_q  <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
      cnt_q    <= cnt_d;
      isrem_q  <= isrem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = (state_q == DONE);
  assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, hold window,
// special cases, start held through DONE and mid-divide reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic [4:0]  reg_waddr_o;
  logic        hold_flag_o;

  int n_chk;
  int n_fail;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  div_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .reg_waddr_o (reg_waddr_o),
    .hold_flag_o (hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request for 40 cycles and records what it saw.
  // start_i stays high for 'keep' cycles; operands are scrambled at cycle 5.
  task automatic run_div(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  wa,
    input  int          keep,
    output int          lat,
    output int          pulses,
    output int          holds,
    output logic [31:0] res,
    output logic [4:0]  wa_o
  );
    lat = -1;
    pulses = 0;
    holds = 0;
    res = '0;
    wa_o = '0;
    op_i = op;
    dividend_i = a;
    divisor_i = b;
    reg_waddr_i = wa;
    start_i = 1'b1;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (hold_flag_o) holds++;
      if (ready_o) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          res = result_o;
          wa_o = reg_waddr_o;
        end
      end
      @(posedge clk);
      #1;
      if (c + 1 >= keep) start_i = 1'b0;
      if (c + 1 == 5) begin
        dividend_i = 32'hDEADBEEF;
        divisor_i = 32'h1;
      end
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    op_i = OP_DIVU;
    dividend_i = '0;
    divisor_i = '0;
    reg_waddr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (result_o !== 32'h0 || ready_o !== 1'b0 ||
        reg_waddr_o !== 5'd0 || hold_flag_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: res=%h rdy=%b wa=%0d hold=%b required 0/0/0/0",
               result_o, ready_o, reg_waddr_o, hold_flag_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu_basic();
    int lat, pulses, holds;
    logic [31:0] res;
    logic [4:0] wa;
    run_div(OP_DIVU, 32'd100, 32'd7, 5'd17, 1, lat, pulses, holds, res, wa);
    n_chk++;
    if (res !== 32'd14) begin
      n_fail++;
      $display("FAIL divu_100_7 result: got %h required %h", res, 32'd14);
    end
    n_chk++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL divu_100_7 latency: got %0d required 33", lat);
    end
    n_chk++;
    if (holds !== 33) begin
      n_fail++;
      $display("FAIL divu_100_7 hold cycles: got %0d required 33", holds);
    end
    n_chk++;
    if (wa !== 5'd17) begin
      n_fail++;
      $display("FAIL divu_100_7 waddr: got %0d required 17", wa);
    end
    n_chk++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL divu_100_7 pulses: got %0d required 1", pulses);
    end
    n_chk++;
    if (result_o !== 32'd14) begin
      n_fail++;
      $display("FAIL divu_100_7 idle hold: got %h required %h", result_o, 32'd14);
    end
  endtask

  task automatic test_signed();
    int lat, pulses, holds;
    logic [31:0] res;
    logic [4:0] wa;
    run_div(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd3, 1, lat, pulses, holds, res, wa);
    n_chk++;
    if (res !== 32'hFFFFFFFD || lat !== 33) begin
      n_fail++;
      $display("FAIL div_m7_2: got %h lat %0d required fffffffd lat 33", res, lat);
    end
    run_div(OP_REM, 32'hFFFFFFF9, 32'd2, 5'd4, 1, lat, pulses, holds, res, wa);
    n_chk++;
    if (res !== 32'hFFFFFFFF || lat !== 33) begin
      n_fail++;
      $display("FAIL rem_m7_2: got %h lat %0d required ffffffff lat 33", res, lat);
    end
    run_div(OP_DIV, 32'd100, 32'hFFFFFFF9, 5'd5, 1, lat, pulses, holds, res, wa);
    n_chk++;
    if (res !== 32'hFFFFFFF2) begin
      n_fail++;
      $display("FAIL div_100_m7: got %h required fffffff2", res);
    end
    run_div(OP_REMU, 32'd100, 32'd7, 5'd6, 1, lat, pulses, holds, res, wa);
    n_chk++;
    if (res !== 32'd2) begin
      n_fail++;
      $display("FAIL remu_100_7: got %h required 00000002", res);
    end
  endtask

  task automatic test_div_zero();
    int lat, pulses, holds;
    logic [31:0] res;
    logic [4:0] wa;
    run_div(OP_REMU, 32'd7, 32'd0, 5'd8, 1, lat, pulses, holds, res, wa);
    n_chk++;
    if (res !== 32'd7 || lat !== 1 || holds !== 1) begin
      n_fail++;
      $display("FAIL remu_7_0: got %h lat %0d hold %0d required 7 lat 1 hold 1",
               res, lat, holds);
    end
    run_div(OP_DIVU, 32'd7, 32'd0, 5'd9, 1, lat, pulses, holds, res, wa);
    n_chk++;
    if (res !== 32'hFFFFFFFF || lat !== 1) begin
      n_fail++;
      $display("FAIL divu_7_0: got %h lat %0d required ffffffff lat 1", res, lat);
    end
    n_chk++;
    if (wa !== 5'd9) begin
      n_fail++;
      $display("FAIL divu_7_0 waddr: got %0d required 9", wa);
    end
  endtask

  task automatic test_overflow();
    int lat, pulses, holds;
    logic [31:0] res;
    logic [4:0] wa;
    run_div(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1, lat, pulses, holds,
            res, wa);
    n_chk++;
    if (res !== 32'h80000000 || lat !== 1 || holds !== 1) begin
      n_fail++;
      $display("FAIL div_ovf: got %h lat %0d hold %0d required 80000000 lat 1 hold 1",
               res, lat, holds);
    end
    run_div(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd11, 1, lat, pulses, holds,
            res, wa);
    n_chk++;
    if (res !== 32'h0 || lat !== 1) begin
      n_fail++;
      $display("FAIL rem_ovf: got %h lat %0d required 0 lat 1", res, lat);
    end
  endtask

  task automatic test_start_held();
    int lat, pulses, holds;
    logic [31:0] res;
    logic [4:0] wa;
    run_div(OP_DIVU, 32'd50, 32'd5, 5'd12, 34, lat, pulses, holds, res, wa);
    n_chk++;
    if (pulses !== 1 || holds !== 33 || res !== 32'd10) begin
      n_fail++;
      $display("FAIL held_normal: pulses %0d hold %0d res %h required 1 33 0000000a",
               pulses, holds, res);
    end
    run_div(OP_DIVU, 32'd5, 32'd0, 5'd13, 2, lat, pulses, holds, res, wa);
    n_chk++;
    if (pulses !== 1 || holds !== 1) begin
      n_fail++;
      $display("FAIL held_special: pulses %0d hold %0d required 1 1", pulses, holds);
    end
  endtask

  task automatic test_reset_mid_calc();
    int pulses;
    pulses = 0;
    op_i = OP_DIVU;
    dividend_i = 32'd1000;
    divisor_i = 32'd3;
    reg_waddr_i = 5'd20;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_chk++;
    if (hold_flag_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid pre-hold: got %b required 1", hold_flag_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_chk++;
    if (hold_flag_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid state: hold %b rdy %b res %h required 0 0 0",
               hold_flag_o, ready_o, result_o);
    end
    for (int c = 0; c < 40; c++) begin
      if (ready_o) pulses++;
      @(posedge clk);
      #2;
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL rst_mid pulses: got %0d required 0", pulses);
    end
  endtask

  task automatic test_after_reset();
    int lat, pulses, holds;
    logic [31:0] res;
    logic [4:0] wa;
    run_div(OP_DIVU, 32'd9, 32'd3, 5'd21, 1, lat, pulses, holds, res, wa);
    n_chk++;
    if (res !== 32'd3 || lat !== 33 || wa !== 5'd21) begin
      n_fail++;
      $display("FAIL divu_9_3: got %h lat %0d wa %0d required 3 lat 33 wa 21",
               res, lat, wa);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_start_held();
    test_reset_mid_calc();
    test_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
